fetch_unit: RTL and testbench

- Parametrised instruction fetch stage for the rv32i core. Owns the fetch PC and issues word requests to instruction memory over a req/gnt + rvalid interface, with up to DEPTH requests in flight.
- Buffers returned words with their PCs in a DEPTH-entry FIFO. Presents them to decode over a valid/ready handshake.
- Supports pipeline redirect (branch/jump) with a flush, and silently drops stale in-flight responses.

---
 rtl/fetch_unit.sv | 176 +++++++++++++++++
 tb/tb_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit : instruction fetch stage for the rv32i core.
//
// Owns the fetch PC and issues word requests to instruction memory over a
// req/gnt + rvalid interface, keeping at most DEPTH requests in flight.
// Returned words are buffered with their PCs in a DEPTH-entry FIFO and
// presented to decode over a valid/ready handshake. A redirect flushes the
// FIFO and converts every in-flight request into a response to be discarded.
//
// Handshakes:
//   imem request : a request is accepted on any cycle with imem_req_o &
//                  imem_gnt_i; imem_addr_o is stable while req is held
//                  without a grant (a redirect withdraws the request).
//   imem response: one word per cycle with imem_rvalid_i, in request order.
//   decode       : a transfer happens on instr_valid_o & instr_ready_i; the
//                  head is held stable while valid is high and ready is low.
//
// Parameters:
//   RESET_VECTOR  fetch PC loaded on reset (word aligned)
//   DEPTH         FIFO entries and maximum in-flight requests (>= 1)
//
// Optional feature (macro FETCH_BYPASS_EN): with the FIFO empty, a kept
// response is shown on instr_o/pc_o in the cycle it arrives; it skips the
// FIFO if decode takes it in that cycle.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   imem_req_o, imem_addr_o       request valid and word address
//   imem_gnt_i                    request accepted
//   imem_rvalid_i, imem_rdata_i   response valid and instruction word
//   redirect_i, redirect_pc_i     flush and restart fetch at a new PC
//   instr_valid_o, instr_o, pc_o  instruction to decode (0 when invalid)
//   instr_ready_i                 decode accepts
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          DEPTH        = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   input  logic        instr_ready_i
);

   localparam int             CW       = $clog2(DEPTH + 1);
   localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW+1:0]  DEPTH_W  = (CW + 2)'(DEPTH);
   localparam logic [PW-1:0]  LAST_IDX = PW'(DEPTH - 1);

   logic [31:0]   r_fetch_pc;
   logic [CW-1:0] r_outstanding;
   logic [CW-1:0] r_discard;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [31:0]   r_fifo_pc    [DEPTH];
   logic [31:0]   r_fifo_instr [DEPTH];

   logic [CW+1:0] w_credits;
   logic          w_req;
   logic          w_grant;
   logic          w_fifo_empty;
   logic          w_resp_keep;
   logic          w_resp_drop;
   logic          w_redir_resp;
   logic [CW-1:0] w_discard_redir;
   logic [31:0]   w_tag_pc;
   logic [31:0]   w_redirect_pc;
   logic          w_bypass;
   logic          w_push;
   logic          w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + PW'(1);
   endfunction

   // Every slot is owed to either a live request, a stale request whose
   // word must still be dropped, or a buffered word.
   assign w_credits    = {2'b00, r_outstanding} + {2'b00, r_discard} + {2'b00, r_count};
   assign w_req        = !rst_i && !redirect_i && (w_credits < DEPTH_W);
   assign w_grant      = w_req && imem_gnt_i;
   assign w_fifo_empty = (r_count == '0);

   // A word is kept only when nothing stale is ahead of it. The outstanding
   // check also ignores words for requests that were lost to a reset.
   assign w_resp_keep  = imem_rvalid_i && !rst_i && !redirect_i &&
                         (r_discard == '0) && (r_outstanding != '0);
   assign w_resp_drop  = imem_rvalid_i && (r_discard != '0);

   // On redirect every live request becomes stale; a word arriving in the
   // same cycle is dropped immediately and so no longer needs a discard slot.
   assign w_redir_resp    = imem_rvalid_i && ((r_discard != '0) || (r_outstanding != '0));
   assign w_discard_redir = r_discard + r_outstanding - CW'(w_redir_resp);

   // Live grants since the last redirect or reset are consecutive words, so
   // the PC of the oldest live request is fetch_pc - 4*outstanding. This
   // stands in for an explicit PC-tag queue.
   assign w_tag_pc      = r_fetch_pc - {{(30 - CW){1'b0}}, r_outstanding, 2'b00};
   assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

`ifdef FETCH_BYPASS_EN
   assign w_bypass = w_resp_keep && w_fifo_empty;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push = w_resp_keep && !(w_bypass && instr_ready_i);
   assign w_pop  = instr_ready_i && !w_fifo_empty;

   assign imem_req_o  = w_req;
   assign imem_addr_o = r_fetch_pc;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fetch_pc    <= RESET_VECTOR;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
      end else if (redirect_i) begin
         r_fetch_pc    <= w_redirect_pc;
         r_outstanding <= '0;
         r_discard     <= w_discard_redir;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
      end else begin
         if (w_grant) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_resp_keep);
         r_discard     <= r_discard - CW'(w_resp_drop);
         r_count       <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
      end
   end

   // FIFO storage needs no reset: entries are only read while counted.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_pc[r_wr_ptr]    <= w_tag_pc;
         r_fifo_instr[r_wr_ptr] <= imem_rdata_i;
      end
   end

   always_comb begin
      instr_valid_o = 1'b0;
      instr_o       = '0;
      pc_o          = '0;
      if (!w_fifo_empty) begin
         instr_valid_o = 1'b1;
         instr_o       = r_fifo_instr[r_rd_ptr];
         pc_o          = r_fifo_pc[r_rd_ptr];
      end else if (w_bypass) begin
         instr_valid_o = 1'b1;
         instr_o       = imem_rdata_i;
         pc_o          = w_tag_pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RV    = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_ready = 1'b0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .imem_req_o   (imem_req),
      .imem_addr_o  (imem_addr),
      .imem_gnt_i   (imem_gnt),
      .imem_rvalid_i(imem_rvalid),
      .imem_rdata_i (imem_rdata),
      .redirect_i   (redirect),
      .redirect_pc_i(redirect_pc),
      .instr_valid_o(instr_valid),
      .instr_o      (instr),
      .pc_o         (pc),
      .instr_ready_i(instr_ready)
   );

   // ---------------- memory model and scoreboard ----------------
   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
      bit          ghost;
   } mem_t;

   typedef struct {
      bit          rst;
      bit          gnt;
      bit          rdy;
      bit          redir;
      logic [31:0] rpc;
      bit          exp_req;
      logic [31:0] exp_addr;
   } vec_t;

   mem_t        pend_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc = RV;
   int          cyc = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   int          errors = 0;
   int          checks = 0;

   bit          tab_active = 1'b0;
   bit          tab_exp_req;
   logic [31:0] tab_exp_addr;

   logic        s_req;
   logic [31:0] s_addr;
   logic        s_valid;
   logic [31:0] s_instr;
   logic        s_deliver;
   logic [31:0] s_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ~a ^ 32'h3C3C_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // One clock: inputs already set by the caller; memory drives its reply,
   // outputs are sampled 1 time unit later, then the model advances.
   task automatic step();
      bit          drive;
      bit          resp_live;
      bit          exp_req;
      bit          exp_valid;
      int          live;
      int          stale_n;
      int          fifo_m;
      int          due;
      logic [31:0] e;
      drive = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
      imem_rvalid = drive;
      imem_rdata  = drive ? mem_word(pend_q[0].addr) : $urandom();
      #1;
      s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
      s_instr = instr; s_pc = pc; s_deliver = 1'b0;
      live = 0; stale_n = 0;
      foreach (pend_q[i]) begin
         if (!pend_q[i].ghost) begin
            if (pend_q[i].stale) stale_n++;
            else live++;
         end
      end
      fifo_m    = exp_q.size() - live;
      resp_live = drive && !pend_q[0].stale && !pend_q[0].ghost && !rst;
      if (tab_active) begin
         chk("tab_req", 32'(imem_req), 32'(tab_exp_req));
         if (tab_exp_req) chk("tab_addr", imem_addr, tab_exp_addr);
      end
      if (rst) begin
         chk("req_in_reset", 32'(imem_req), 32'(0));
         if (drive) void'(pend_q.pop_front());
         exp_q.delete();
         exp_pc = RV;
         // Words owed to requests lost in reset come back no later than the
         // cycle after a two-cycle reset ends, ahead of any new request.
         foreach (pend_q[i]) begin
            pend_q[i].ghost = 1'b1;
            if (pend_q[i].due > cyc + 2 + i) pend_q[i].due = cyc + 2 + i;
         end
      end else begin
         exp_req   = !redirect && ((stale_n + live + fifo_m) < DEPTH);
         exp_valid = (fifo_m > 0) || (BYP && resp_live && (fifo_m == 0) && !redirect);
         chk("req", 32'(imem_req), 32'(exp_req));
         chk("valid", 32'(instr_valid), 32'(exp_valid));
         if (instr_valid && instr_ready) begin
            s_deliver = 1'b1;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL deliver at cycle %0d: got pc %h, expected no instruction", cyc, pc);
            end else begin
               e = exp_q.pop_front();
               chk("pc", pc, e);
               chk("instr", instr, mem_word(e));
            end
         end else if (!instr_valid) begin
            chk("idle_instr", instr, 32'h0);
            chk("idle_pc", pc, 32'h0);
         end
         if (exp_req && imem_gnt) begin
            chk("addr", imem_addr, exp_pc);
            due = cyc + $urandom_range(lat_min, lat_max);
            if (pend_q.size() > 0 && due <= pend_q[pend_q.size()-1].due)
               due = pend_q[pend_q.size()-1].due + 1;
            pend_q.push_back('{addr: exp_pc, due: due, stale: 1'b0, ghost: 1'b0});
            exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
         end
         if (drive) void'(pend_q.pop_front());
         if (redirect) begin
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            exp_q.delete();
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic set_in(input bit r, input bit g, input bit rd, input bit rdir, input logic [31:0] rp);
      rst = r; imem_gnt = g; instr_ready = rd; redirect = rdir; redirect_pc = rp;
   endtask

   task automatic drain();
      int n;
      n = 0;
      set_in(0, 0, 1, 0, 32'h0);
      while ((pend_q.size() > 0 || exp_q.size() > 0) && n < 60) begin
         step();
         n++;
      end
      if (pend_q.size() > 0 || exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      end
   endtask

   // Step until the DUT raises imem_req_o (bounded); the grant input is
   // whatever the caller set.
   task automatic step_until_req(input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!s_req && n < 30);
      if (!s_req) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got req=0, expected req=1", name);
      end
   endtask

   // ---------------- stimulus ----------------
   vec_t tab[17];

   initial begin : main
      int g;
      int v;
      int n;
      tab[0]  = '{1, 0, 0, 0, 32'h0,   0, 32'h0};
      tab[1]  = '{1, 0, 0, 0, 32'h0,   0, 32'h0};
      tab[2]  = '{0, 1, 0, 0, 32'h0,   1, 32'h0};
      tab[3]  = '{0, 1, 0, 0, 32'h0,   1, 32'h4};
      tab[4]  = '{0, 1, 0, 0, 32'h0,   0, 32'h0};
      tab[5]  = '{0, 1, 0, 0, 32'h0,   0, 32'h0};
      tab[6]  = '{0, 0, 0, 0, 32'h0,   0, 32'h0};
      tab[7]  = '{0, 0, 1, 0, 32'h0,   0, 32'h0};
      tab[8]  = '{0, 0, 1, 0, 32'h0,   1, 32'h8};
      tab[9]  = '{0, 0, 1, 0, 32'h0,   1, 32'h8};
      tab[10] = '{0, 0, 1, 0, 32'h0,   1, 32'h8};
      tab[11] = '{0, 1, 0, 0, 32'h0,   1, 32'h8};
      tab[12] = '{0, 1, 0, 0, 32'h0,   1, 32'hC};
      tab[13] = '{0, 1, 0, 0, 32'h0,   0, 32'h0};
      tab[14] = '{0, 0, 1, 1, 32'h203, 0, 32'h0};
      tab[15] = '{0, 1, 1, 0, 32'h0,   1, 32'h200};
      tab[16] = '{0, 1, 1, 0, 32'h0,   1, 32'h204};

      // Reset, depth-2 stall, held request, redirect: fixed 1-cycle memory.
      lat_min = 1; lat_max = 1;
      tab_active = 1'b1;
      for (int i = 0; i < 17; i++) begin
         set_in(tab[i].rst, tab[i].gnt, tab[i].rdy, tab[i].redir, tab[i].rpc);
         tab_exp_req  = tab[i].exp_req;
         tab_exp_addr = tab[i].exp_addr;
         step();
         if (i == 1) begin
            chk("reset_valid", 32'(s_valid), 32'(0));
            chk("reset_instr", s_instr, 32'h0);
            chk("reset_pc", s_pc, 32'h0);
         end
      end
      tab_active = 1'b0;
      drain();

      // Two requests in flight become stale on redirect to 0x203.
      lat_min = 4; lat_max = 4;
      set_in(0, 0, 1, 1, 32'h10); step();
      set_in(0, 1, 1, 0, 32'h0);  step();
      chk("stale_addr0", s_addr, 32'h10);
      step();
      chk("stale_addr1", s_addr, 32'h14);
      set_in(0, 1, 1, 1, 32'h203); step();
      set_in(0, 1, 1, 0, 32'h0);
      step_until_req("redir");
      chk("redir_addr", s_addr, 32'h200);
      n = 0;
      do begin
         step();
         n++;
      end while (!s_deliver && n < 30);
      chk("redir_first_pc", s_pc, 32'h200);
      drain();

      // PC wrap at the top of the address space.
      lat_min = 1; lat_max = 1;
      set_in(0, 0, 1, 1, 32'hFFFF_FFFF); step();
      set_in(0, 1, 1, 0, 32'h0); step();
      chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
      step();
      chk("wrap_addr1", s_addr, 32'h0000_0000);
      drain();

      // Response-to-valid latency for a single request.
      set_in(0, 1, 1, 0, 32'h0);
      n = 0;
      do begin
         g = cyc;
         step();
         n++;
      end while (!s_req && n < 30);
      imem_gnt = 1'b0;
      n = 0;
      do begin
         v = cyc;
         step();
         n++;
      end while (!s_valid && n < 30);
      chk("latency", 32'(v - g - 1), BYP ? 32'd0 : 32'd1);
      drain();

      // Reset with one buffered word and one request still in flight.
      lat_min = 3; lat_max = 3;
      set_in(0, 1, 0, 0, 32'h0); step();
      lat_min = 6; lat_max = 6;
      step(); step(); step();
      set_in(1, 1, 1, 0, 32'h0); step();
      step();
      chk("rst_mid_valid", 32'(s_valid), 32'(0));
      chk("rst_mid_req", 32'(s_req), 32'(0));
      lat_min = 1; lat_max = 3;
      set_in(0, 1, 1, 0, 32'h0);
      step();
      chk("rst_first_req", 32'(s_req), 32'(1));
      chk("rst_first_addr", s_addr, RV);
      step(); step(); step();
      drain();

      // Random traffic with redirects, variable latency and decode stalls.
      lat_min = 1; lat_max = 3;
      for (int i = 0; i < 400; i++) begin
         set_in(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 24) == 0, $urandom());
         step();
      end
      drain();
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
